// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx instance between NREQ byte-stream requesters. Ownership
//   is granted round-robin per packet: the owner keeps the UART until it sends
//   a byte flagged last. The arbiter drives start/data into uart_tx, follows
//   its busy flag and raises a one-cycle timeout pulse if busy never rises.
//
// Ports
//   clk          system clock
//   resetn       synchronous, active-low reset
//   req_valid    [NREQ]    requester i presents a byte on req_data[8i+7:8i]
//   req_data     [8*NREQ]  packed request bytes
//   req_last     [NREQ]    byte of requester i ends its packet
//   req_ready    [NREQ]    registered one-hot accept strobe
//   tx_data      [8]       byte to uart_tx
//   tx_start     1         single-cycle start pulse to uart_tx
//   tx_busy      1         busy flag from uart_tx
//   grant_valid  1         a packet lock is held
//   grant_id     [IDW]     current or most recent owner
//   timeout_err  1         single-cycle pulse: tx_busy never rose after start
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int IDW          = 2,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              grant_valid,
  output logic [IDW-1:0]    grant_id,
  output logic              timeout_err
);

  localparam int CW = $clog2(BUSY_TIMEOUT);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ACCEPT    = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic           last_q;
  logic [CW-1:0]  busy_cnt;

  // Unpack the request bus into one byte per requester.
  logic [7:0] req_byte [NREQ];
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  // Round-robin pick: rotate valids so rr_ptr lands at bit 0, take the lowest
  // set bit, then rotate the offset back into a requester index.
  logic [2*NREQ-1:0] valid_dbl;
  logic [2*NREQ-1:0] valid_sh;
  logic [NREQ-1:0]   valid_rot;
  logic              pick_found;
  logic [IDW:0]      pick_off;
  logic [IDW:0]      pick_sum;
  logic [IDW-1:0]    pick_idx;

  assign valid_dbl = {req_valid, req_valid};
  assign valid_sh  = valid_dbl >> rr_ptr;
  assign valid_rot = valid_sh[NREQ-1:0];

  // NOTE: every signal assigned here gets a value before any branch so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    // Descending scan: the last hit written is the lowest offset.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        pick_found = 1'b1;
        pick_off   = (IDW+1)'(k);
      end
    end
    pick_sum = {1'b0, rr_ptr} + pick_off;
    if (pick_sum >= (IDW+1)'(NREQ)) begin
      pick_idx = IDW'(pick_sum - (IDW+1)'(NREQ));
    end else begin
      pick_idx = IDW'(pick_sum);
    end
  end

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    if (idx == IDW'(NREQ - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // NOTE: reset is sampled on the clock edge only (synchronous); all state
  // and outputs return to zero on that edge, abandoning any transfer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      last_q      <= 1'b0;
      busy_cnt    <= '0;
      req_ready   <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          // A UART that is still busy (ours or not) blocks any accept.
          if (!tx_busy) begin
            if (grant_valid) begin
              // Locked: only the owner may continue its packet.
              if (req_valid[grant_id]) begin
                req_ready <= onehot(grant_id);
                state     <= S_ACCEPT;
              end
            end else if (pick_found) begin
              grant_id    <= pick_idx;
              grant_valid <= 1'b1;
              req_ready   <= onehot(pick_idx);
              state       <= S_ACCEPT;
            end
          end
        end

        S_ACCEPT: begin
          // The byte transfers on this edge since req_ready is high now.
          tx_data   <= req_byte[grant_id];
          last_q    <= req_last[grant_id];
          req_ready <= '0;
          tx_start  <= 1'b1;
          busy_cnt  <= '0;
          state     <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (tx_busy) begin
            busy_cnt <= '0;
            state    <= S_WAIT_DONE;
          end else if (!tx_start) begin
            // The timeout window opens once the start pulse has ended.
            if (busy_cnt == CW'(BUSY_TIMEOUT - 1)) begin
              timeout_err <= 1'b1;
              grant_valid <= 1'b0;
              rr_ptr      <= next_idx(grant_id);
              busy_cnt    <= '0;
              state       <= S_IDLE;
            end else begin
              busy_cnt <= busy_cnt + 1'b1;
            end
          end
        end

        S_WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_q) begin
              grant_valid <= 1'b0;
              rr_ptr      <= next_idx(grant_id);
            end
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter: per-requester byte queues, a simple
//   uart_tx busy model, an event log of ready/start/timeout activity, and
//   hand-computed expectations for each scenario.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int BT   = 64;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              grant_valid;
  logic [IDW-1:0]    grant_id;
  logic              timeout_err;

  always #20 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .BUSY_TIMEOUT(BT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy rises the cycle after start, lasts 3..21 cycles.
  logic       mbusy;
  logic [7:0] mcnt;
  logic       ext_busy = 1'b0;
  logic       model_on = 1'b1;
  int         n_model  = 0;
  assign tx_busy = mbusy | ext_busy;

  always @(posedge clk) begin
    if (!resetn) begin
      mbusy <= 1'b0;
      mcnt  <= 8'd0;
    end else if (tx_start && model_on) begin
      mbusy   <= 1'b1;
      mcnt    <= 8'(2 + (n_model * 7) % 19);
      n_model <= n_model + 1;
    end else if (mbusy) begin
      if (mcnt == 8'd0) mbusy <= 1'b0;
      else              mcnt  <= mcnt - 8'd1;
    end
  end

  // Requester queues.
  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } item_t;

  item_t qmem [NREQ][32];
  int    qh   [NREQ];
  int    qt   [NREQ];
  bit    pend [NREQ];

  task automatic push(input int r, input logic [7:0] d, input logic last);
    qmem[r][qt[r]] = {d, last};
    qt[r]++;
  endtask

  // Event log.
  logic [7:0]     log_d   [64];
  logic [IDW-1:0] log_id  [64];
  int             st_cyc  [64];
  int             rdy_cyc [64];
  int n_log = 0, n_rdy = 0, n_to = 0, viol = 0;
  int vrise_cyc = 0, fall_cyc = 0, to_gap = 0;
  logic to_gv = 1'b0;
  logic [NREQ-1:0] prev_valid = '0, prev_ready = '0;
  logic prev_start = 1'b0, prev_to = 1'b0;

  always @(negedge clk) begin
    // Drive requesters: pop a byte that transferred on the last edge.
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i]) qh[i]++;
      pend[i] = req_ready[i] && req_valid[i];
    end
    for (int i = 0; i < NREQ; i++) begin
      if (qh[i] < qt[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = qmem[i][qh[i]].d;
        req_last[i]        = qmem[i][qh[i]].last;
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    if (req_valid != '0 && prev_valid == '0) vrise_cyc = cyc;
    prev_valid = req_valid;

    if (req_ready != '0) begin
      rdy_cyc[n_rdy] = cyc;
      n_rdy++;
      if ($countones(req_ready) != 1) viol++;
      if (prev_ready != '0) viol++;
    end
    prev_ready = req_ready;

    if (tx_start) begin
      log_d[n_log]  = tx_data;
      log_id[n_log] = grant_id;
      st_cyc[n_log] = cyc;
      n_log++;
    end
    if (prev_start && !tx_start) fall_cyc = cyc;
    prev_start = tx_start;

    if (timeout_err) begin
      to_gap = cyc - fall_cyc;
      to_gv  = grant_valid;
      n_to++;
      if (prev_to) viol++;
    end
    prev_to = timeout_err;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_starts(input int n, input string tag);
    int k = 0;
    while (n_log < n && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(n_log >= n), 32'd1);
  endtask

  task automatic idle_gap();
    repeat (30) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"},   32'(req_ready),   32'd0);
    chk({tag, "_start"},   32'(tx_start),    32'd0);
    chk({tag, "_data"},    32'(tx_data),     32'd0);
    chk({tag, "_gvalid"},  32'(grant_valid), 32'd0);
    chk({tag, "_gid"},     32'(grant_id),    32'd0);
    chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, r0, k, d;

    // Reset state.
    repeat (3) @(negedge clk);
    check_zero("rst");
    resetn = 1'b1;
    @(negedge clk);

    // 1: single requester, 3-byte packet.
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    wait_starts(3, "t1_starts");
    k = 0;
    while (grant_valid && k < 200) begin @(negedge clk); k++; end
    chk("t1_release", 32'(grant_valid), 32'd0);
    chk("t1_nstarts_at_release", 32'(n_log), 32'd3);
    chk("t1_busy_at_release", 32'(tx_busy), 32'd0);
    chk("t1_d0", 32'(log_d[0]), 32'h41);
    chk("t1_d1", 32'(log_d[1]), 32'h42);
    chk("t1_d2", 32'(log_d[2]), 32'h43);
    chk("t1_id2", 32'(log_id[2]), 32'd0);
    chk("t1_lat_ready", 32'(rdy_cyc[0] - vrise_cyc), 32'd1);
    chk("t1_lat_start", 32'(st_cyc[0] - rdy_cyc[0]), 32'd1);
    idle_gap();
    // rr_ptr is now 1: req1 beats req0.
    push(0, 8'hA0, 1'b1);
    push(1, 8'hA1, 1'b1);
    wait_starts(5, "t1_rr_starts");
    chk("t1_rr_first", 32'(log_id[3]), 32'd1);
    chk("t1_rr_second", 32'(log_id[4]), 32'd0);
    idle_gap();

    // 2: all requesting from reset, single-byte packets.
    do_reset();
    b  = n_log;
    r0 = n_rdy;
    push(0, 8'hB0, 1'b1);
    push(1, 8'hB1, 1'b1);
    push(2, 8'hB2, 1'b1);
    push(3, 8'hB3, 1'b1);
    push(0, 8'hB4, 1'b1);
    wait_starts(b + 5, "t2_starts");
    for (int i = 0; i < 5; i++) chk($sformatf("t2_id%0d", i), 32'(log_id[b+i]), 32'(i % 4));
    chk("t2_data4", 32'(log_d[b+4]), 32'hB4);
    chk("t2_nready", 32'(n_rdy - r0), 32'd5);
    idle_gap();

    // 3: req1 holds the lock mid-packet; req2 must wait.
    b = n_log;
    push(1, 8'h10, 1'b0);
    wait_starts(b + 1, "t3_first");
    idle_gap();
    push(2, 8'h20, 1'b1);
    r0 = n_rdy;
    repeat (50) @(negedge clk);
    chk("t3_no_ready", 32'(n_rdy - r0), 32'd0);
    chk("t3_locked", 32'(grant_valid), 32'd1);
    chk("t3_owner", 32'(grant_id), 32'd1);
    push(1, 8'h11, 1'b1);
    wait_starts(b + 3, "t3_starts");
    chk("t3_id1", 32'(log_id[b+1]), 32'd1);
    chk("t3_d1", 32'(log_d[b+1]), 32'h11);
    chk("t3_id2", 32'(log_id[b+2]), 32'd2);
    chk("t3_d2", 32'(log_d[b+2]), 32'h20);
    idle_gap();

    // 4: UART never responds. rr_ptr=3, so req3 wins, then times out.
    model_on = 1'b0;
    b = n_log;
    push(3, 8'h30, 1'b0);
    push(0, 8'h40, 1'b1);
    k = 0;
    while (n_to == 0 && k < 400) begin @(negedge clk); k++; end
    model_on = 1'b1;
    chk("t4_timeout_seen", 32'(n_to), 32'd1);
    chk("t4_gap", 32'(to_gap), 32'(BT));
    chk("t4_unlocked", 32'(to_gv), 32'd0);
    wait_starts(b + 2, "t4_starts");
    chk("t4_id0", 32'(log_id[b]), 32'd3);
    chk("t4_id1", 32'(log_id[b+1]), 32'd0);
    chk("t4_d1", 32'(log_d[b+1]), 32'h40);
    idle_gap();

    // 5: reset during WAIT_DONE.
    b = n_log;
    push(1, 8'h61, 1'b0);
    wait_starts(b + 1, "t5_start");
    repeat (2) @(negedge clk);
    chk("t5_in_xfer", 32'(tx_busy), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check_zero("t5");
    resetn = 1'b1;
    @(negedge clk);
    b = n_log;
    push(3, 8'h73, 1'b1);
    wait_starts(b + 1, "t5_req3");
    chk("t5_req3_id", 32'(log_id[b]), 32'd3);
    idle_gap();
    // rr_ptr wrapped 3 -> 0: req0 before req3.
    b = n_log;
    push(3, 8'h83, 1'b1);
    push(0, 8'h80, 1'b1);
    wait_starts(b + 2, "t5_wrap");
    chk("t5_wrap_first", 32'(log_id[b]), 32'd0);
    chk("t5_wrap_second", 32'(log_id[b+1]), 32'd3);
    idle_gap();

    // 6: external busy blocks accept until it falls.
    ext_busy = 1'b1;
    b  = n_log;
    r0 = n_rdy;
    push(0, 8'h66, 1'b1);
    repeat (20) @(negedge clk);
    chk("t6_blocked", 32'(n_rdy - r0), 32'd0);
    d = cyc;
    ext_busy = 1'b0;
    wait_starts(b + 1, "t6_start");
    chk("t6_ready_lat", 32'(rdy_cyc[r0] - d), 32'd1);
    chk("t6_data", 32'(log_d[b]), 32'h66);
    idle_gap();

    chk("handshake_violations", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
